// File: rtl/fdct4_pkg.sv
// rtl/fdct4_pkg.sv - shared constants and types for the serial 4-point forward DCT
//
// Purpose: sample/coefficient widths, DCT coefficient constants and the
// controller state enum used by fdct4_serial and fdct4_butterfly.
// Ports: none (package).

package fdct4_pkg;

  localparam int IN_W  = 16;
  localparam int OUT_W = 24;

  typedef logic signed [IN_W-1:0]  sample_t;
  typedef logic signed [IN_W:0]    half_t;
  typedef logic signed [OUT_W-1:0] coef_t;

  localparam coef_t C64 = coef_t'(64);
  localparam coef_t C83 = coef_t'(83);
  localparam coef_t C36 = coef_t'(36);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } state_e;

endpackage

// File: rtl/fdct4_butterfly.sv
// rtl/fdct4_butterfly.sv - even/odd input butterfly of the 4-point forward DCT
//
// Purpose: first DCT stage, purely combinational.
// Ports:
//   x0..x3 : input  16-bit signed samples
//   e0, e1 : output 17-bit signed sums x0+x3, x1+x2
//   o0, o1 : output 17-bit signed differences x0-x3, x1-x2

module fdct4_butterfly
  import fdct4_pkg::*;
(
  input  sample_t x0,
  input  sample_t x1,
  input  sample_t x2,
  input  sample_t x3,
  output half_t   e0,
  output half_t   e1,
  output half_t   o0,
  output half_t   o1
);

  // One extra bit makes every sum and difference exact.
  assign e0 = half_t'(x0) + half_t'(x3);
  assign e1 = half_t'(x1) + half_t'(x2);
  assign o0 = half_t'(x0) - half_t'(x3);
  assign o1 = half_t'(x1) - half_t'(x2);

endmodule

// File: rtl/fdct4_serial.sv
// rtl/fdct4_serial.sv - 4-point forward DCT with serialised coefficient output
//
// Purpose: accepts one set of four samples, computes X0..X3 in one cycle,
// then streams them out one per handshake with their index.
// Optional feature macro: FDCT4_ROUND_EN (round and arithmetic-shift each
// coefficient right by SHIFT).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid, in_ready  : input sample-set handshake
//   d_in_1..d_in_4      : 16-bit signed samples x0..x3
//   out_valid, out_ready: output coefficient handshake
//   out_idx             : index k of the coefficient on d_out
//   d_out               : 24-bit signed coefficient Xk

module fdct4_serial
  import fdct4_pkg::*;
#(
  parameter int SHIFT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  d_in_1,
  input  logic signed [IN_W-1:0]  d_in_2,
  input  logic signed [IN_W-1:0]  d_in_3,
  input  logic signed [IN_W-1:0]  d_in_4,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_idx,
  output logic signed [OUT_W-1:0] d_out
);

  if (SHIFT < 1 || SHIFT > 8) begin : g_shift_check
    $error("fdct4_serial: SHIFT must be within 1..8");
  end

  state_e                    state_q, state_d;
  logic [1:0]                k_q, k_d;
  logic [3:0][IN_W-1:0]      x_q, x_d;
  logic [3:0][OUT_W-1:0]     coef_q, coef_d;
  coef_t                     d_out_q, d_out_d;

  half_t                     e0, e1, o0, o1;
  logic signed [IN_W+1:0]    even_sum, even_diff;
  coef_t                     xk_raw [4];
  coef_t                     xk     [4];

  fdct4_butterfly u_butterfly (
    .x0 (sample_t'(x_q[0])),
    .x1 (sample_t'(x_q[1])),
    .x2 (sample_t'(x_q[2])),
    .x3 (sample_t'(x_q[3])),
    .e0 (e0),
    .e1 (e1),
    .o0 (o0),
    .o1 (o1)
  );

  assign even_sum  = (IN_W+2)'(e0) + (IN_W+2)'(e1);
  assign even_diff = (IN_W+2)'(e0) - (IN_W+2)'(e1);

  // Full-range inputs stay inside 24 bits (|X| <= 0x800000), so no clamp.
  always_comb begin
    xk_raw[0] = C64 * coef_t'(even_sum);
    xk_raw[1] = C83 * coef_t'(o0) + C36 * coef_t'(o1);
    xk_raw[2] = C64 * coef_t'(even_diff);
    xk_raw[3] = C36 * coef_t'(o0) - C83 * coef_t'(o1);
  end

`ifdef FDCT4_ROUND_EN
  localparam coef_t RND = coef_t'(1) <<< (SHIFT - 1);

  // Round-half-up then arithmetic shift; the largest positive X0 plus the
  // rounding offset still fits, so the sum cannot wrap.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      xk[i] = (xk_raw[i] + RND) >>> SHIFT;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      xk[i] = xk_raw[i];
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    coef_d  = coef_q;
    d_out_d = d_out_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d[0]  = d_in_1;
          x_d[1]  = d_in_2;
          x_d[2]  = d_in_3;
          x_d[3]  = d_in_4;
          state_d = CALC;
        end
      end
      CALC: begin
        for (int i = 0; i < 4; i++) begin
          coef_d[i] = xk[i];
        end
        // X0 is loaded straight into the output register so it is
        // presented on the first EMIT cycle.
        d_out_d = xk[0];
        k_d     = 2'd0;
        state_d = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          if (k_q == 2'd3) begin
            // k and d_out stay put; out_valid drops with the state.
            state_d = IDLE;
          end else begin
            k_d     = k_q + 2'd1;
            d_out_d = coef_q[k_q + 2'd1];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      x_q     <= '0;
      coef_q  <= '0;
      d_out_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      coef_q  <= coef_d;
      d_out_q <= d_out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_idx   = k_q;
  assign d_out     = d_out_q;

endmodule

// File: tb/tb_fdct4_serial.sv
// tb/tb_fdct4_serial.sv - self-checking bench for fdct4_serial

module tb_fdct4_serial;

  localparam int SHIFT = 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] d_in_1, d_in_2, d_in_3, d_in_4;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_idx;
  logic signed [23:0] d_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int idx;
    int val;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fdct4_serial #(.SHIFT(SHIFT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_in_1    (d_in_1),
    .d_in_2    (d_in_2),
    .d_in_3    (d_in_3),
    .d_in_4    (d_in_4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .d_out     (d_out)
  );

  task automatic chk(input string nm, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  function automatic int pick(input int plain, input int rnd);
`ifdef FDCT4_ROUND_EN
    return rnd;
`else
    return plain;
`endif
  endfunction

  // Reference DCT straight from the defining equations.
  function automatic void push_model(input int a, input int b, input int c, input int d);
    int e0, e1, o0, o1;
    int xs[4];
    exp_t item;
    e0 = a + d;
    e1 = b + c;
    o0 = a - d;
    o1 = b - c;
    xs[0] = 64 * (e0 + e1);
    xs[1] = 83 * o0 + 36 * o1;
    xs[2] = 64 * (e0 - e1);
    xs[3] = 36 * o0 - 83 * o1;
    for (int k = 0; k < 4; k++) begin
`ifdef FDCT4_ROUND_EN
      xs[k] = (xs[k] + (1 << (SHIFT - 1))) >>> SHIFT;
`endif
      item.idx = k;
      item.val = xs[k];
      exp_q.push_back(item);
    end
  endfunction

  // Every presented coefficient is checked against the model queue.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output got=%0d idx=%0d expected=none", d_out, out_idx);
      end else begin
        chk("model_d_out", d_out, exp_q[0].val);
        chk("model_out_idx", out_idx, exp_q[0].idx);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Drives one sample set from an IDLE cycle; it is accepted at the next edge.
  task automatic send(input int a, input int b, input int c, input int d);
    @(posedge clk); #1;
    in_valid = 1'b1;
    d_in_1 = 16'(a);
    d_in_2 = 16'(b);
    d_in_3 = 16'(c);
    d_in_4 = 16'(d);
    push_model(a, b, c, d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input string nm, input int a, input int b, input int c, input int d,
                         input int l0, input int l1, input int l2, input int l3);
    int lit[4];
    lit[0] = l0; lit[1] = l1; lit[2] = l2; lit[3] = l3;
    send(a, b, c, d);
    @(negedge clk);
    chk({nm, "_calc_valid"}, out_valid, 0);
    chk({nm, "_calc_ready"}, in_ready, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({nm, "_valid"}, out_valid, 1);
      chk({nm, "_idx"}, out_idx, k);
      chk({nm, "_d_out"}, d_out, lit[k]);
    end
    @(negedge clk);
    chk({nm, "_end_ready"}, in_ready, 1);
    chk({nm, "_end_valid"}, out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    d_in_1 = 16'sd1; d_in_2 = 16'sd1; d_in_3 = 16'sd1; d_in_4 = 16'sd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_d_out", d_out, 0);
    chk("rst_out_idx", out_idx, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    run_vec("impulse0", 1, 0, 0, 0, pick(64, 32), pick(83, 42), pick(64, 32), pick(36, 18));
    run_vec("impulse1", 0, 1, 0, 0, pick(64, 32), pick(36, 18), pick(-64, -32), pick(-83, -41));
    run_vec("ones", 1, 1, 1, 1, pick(256, 128), 0, 0, 0);
    run_vec("max", 32767, 32767, 32767, 32767, pick(8388352, 4194176), 0, 0, 0);
    run_vec("min", -32768, -32768, -32768, -32768, pick(-8388608, -4194304), 0, 0, 0);
    run_vec("mixed", 100, -200, 300, -400,
            pick(-12800, -6400), pick(23500, 11750), pick(-25600, -12800), pick(59500, 29750));

    // Backpressure at k=1, with a stray in_valid that must be ignored.
    send(1, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("bp_x0", d_out, pick(64, 32));
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    d_in_1 = 16'sd5; d_in_2 = 16'sd5; d_in_3 = 16'sd5; d_in_4 = 16'sd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_d_out", d_out, pick(83, 42));
      chk("bp_hold_idx", out_idx, 1);
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_release_d_out", d_out, pick(83, 42));
    @(negedge clk);
    chk("bp_x2", d_out, pick(64, 32));
    chk("bp_x2_idx", out_idx, 2);
    @(negedge clk);
    chk("bp_x3", d_out, pick(36, 18));
    chk("bp_x3_idx", out_idx, 3);
    @(negedge clk);
    chk("bp_end_ready", in_ready, 1);
    chk("bp_end_valid", out_valid, 0);

    // Reset during EMIT at k=2 with out_ready high.
    send(1, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_pre_d_out", d_out, pick(64, 32));
    chk("mid_rst_pre_idx", out_idx, 2);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_d_out", d_out, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_idx", out_idx, 0);
    run_vec("after_rst", 0, 1, 0, 0, pick(64, 32), pick(36, 18), pick(-64, -32), pick(-83, -41));

    repeat (3) @(negedge clk);
    chk("model_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fdct4_serial.md
FDCT4_SERIAL -- requirements
Module: fdct4_serial

Interface
- REQ-001 SHALL have parameter SHIFT, default 1: right-shift amount applied when FDCT4_ROUND_EN is defined; legal range 1..8.
- REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-004 SHALL have port in_valid, input, 1 bit: the input sample set is valid.
- REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a sample set.
- REQ-006 SHALL have ports d_in_1, d_in_2, d_in_3 and d_in_4, each input, 16 bits, signed: samples x0..x3.
- REQ-007 SHALL have port out_valid, output, 1 bit: d_out and out_idx are valid.
- REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts the current coefficient.
- REQ-009 SHALL have port out_idx, output, 2 bits: index k of the coefficient Xk on d_out.
- REQ-010 SHALL have port d_out, output, 24 bits, signed: the forward 4-point DCT coefficient.

Function
- REQ-011 SHALL accept a sample set only on a cycle with in_valid=1 and in_ready=1, registering d_in_1..d_in_4.
- REQ-012 SHALL compute the forward 4-point DCT: e0=x0+x3, e1=x1+x2, o0=x0-x3, o1=x1-x2.
- REQ-013 SHALL then compute X0=64(e0+e1), X1=83·o0+36·o1, X2=64(e0-e1) and X3=36·o0-83·o1.
- REQ-014 SHALL hold e/o at 17 bits and e0±e1 at 18 bits, with all products and sums in 24-bit signed two's complement; no overflow is possible and no saturation is applied.
- REQ-015 SHALL implement an FSM with states IDLE, CALC and EMIT.
- REQ-016 SHALL assert in_ready only in IDLE.
- REQ-017 SHALL move IDLE->CALC on accept, and SHALL move CALC->EMIT unconditionally after 1 cycle, registering X0..X3 in CALC.
- REQ-018 SHALL, in EMIT, assert out_valid and present Xk on d_out with out_idx=k, k counting 0,1,2,3.
- REQ-019 SHALL advance k only on a cycle with out_valid=1 and out_ready=1.
- REQ-020 SHALL, while out_ready=0, hold d_out and out_idx stable.
- REQ-021 SHALL move EMIT->IDLE on acceptance with k=3, with no wrap of k to 0 while still in EMIT.
- REQ-022 SHALL give X0 out_valid 2 cycles after the accept cycle, and with out_ready held high SHALL emit all four coefficients on consecutive cycles, for 6 cycles from accept to IDLE.
- REQ-023 SHALL ignore in_valid while not in IDLE; the producer must hold the data.
- REQ-024 SHALL hold out_valid=0 in IDLE and CALC, with d_out holding its last value.

Reset
- REQ-025 SHALL, on reset=1 at a clock edge, set state=IDLE, k=0, out_valid=0, d_out=0, out_idx=0 and all coefficient registers to 0.
- REQ-026 SHALL have in_ready=1 in the first cycle after reset is released.
- REQ-027 SHALL, on reset asserted during CALC or EMIT, discard the pending sample set and emit no further coefficients.
- REQ-028 SHALL give reset priority over a simultaneous in_valid or out_ready.

Configuration
- REQ-029 SHALL, when FDCT4_ROUND_EN is defined, output each coefficient as (Xk + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift), sign-extended to 24 bits.
- REQ-030 SHALL, when FDCT4_ROUND_EN is defined, apply the rounding in CALC with no added latency.
- REQ-031 SHALL, when FDCT4_ROUND_EN is undefined, output the unscaled Xk, with SHIFT unused.

Structure
- REQ-032 SHALL place in shared package fdct4_pkg: the coefficient constants C64=64, C83=83 and C36=36, the widths IN_W=16 and OUT_W=24, and the state enum {IDLE, CALC, EMIT}.
- REQ-033 SHALL use the combinational sub-module fdct4_butterfly (inputs x0..x3; outputs e0, e1, o0, o1), instantiated once.
- REQ-034 SHALL implement the multiplies as shift-add or '*' on constants, with no shared multiplier time-multiplexing.

Verification
- REQ-035 SHALL verify, with FDCT4_ROUND_EN undefined: x=(1,0,0,0), out_ready=1 -> X0..X3 = 64, 83, 64, 36 with out_idx 0..3 on cycles accept+2..accept+5.
- REQ-036 SHALL verify, with FDCT4_ROUND_EN undefined: x=(0,1,0,0) -> 64, 36, -64, -83; and x=(1,1,1,1) -> 256, 0, 0, 0.
- REQ-037 SHALL verify extremes: x=(32767,32767,32767,32767) -> X0=0x7FFF00, others 0; and x=(-32768,-32768,-32768,-32768) -> X0=0x800000, others 0.
- REQ-038 SHALL verify backpressure: out_ready=0 for 3 cycles at k=1 -> d_out=83 and out_idx=1 held; in_ready=0 throughout; then X2 and X3 follow.
- REQ-039 SHALL verify reset mid-EMIT: reset at k=2 -> next cycle out_valid=0, d_out=0, in_ready=1; a new set (0,1,0,0) yields 64, 36, -64, -83.
- REQ-040 SHALL verify, with FDCT4_ROUND_EN defined and SHIFT=1: x=(1,0,0,0) -> 32, 42, 32, 18; and x=(0,1,0,0) -> 32, 18, -32, -41.
